// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: EX-stage ALU sequencer (AND/OR/ADD/SUB single-cycle, SLL iterative or barrel via BARREL_SHIFT_EN)
module alu_seq_ctrl #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             stall,
    output logic             illegal_op
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0100;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d, result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               zero_q, zero_d, done_q, done_d, illegal_q, illegal_d;
    logic [SHAMT_W-1:0] shamt;
    assign shamt = b[SHAMT_W-1:0];
    // next-state, accumulator and result selection; flush beats start and shift completion
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        if (state_q == IDLE) begin
            if (start && !flush) begin
                done_d = 1'b1;
                case (operation)
                    OP_AND: result_d = a & b;
                    OP_OR:  result_d = a | b;
                    OP_ADD: result_d = a + b;
                    OP_SUB: result_d = a - b;
`ifdef BARREL_SHIFT_EN
                    OP_SLL: result_d = a << shamt;
`else
                    OP_SLL: begin
                        result_d = (shamt == '0) ? a : result_q;
                        done_d   = (shamt == '0);
                        acc_d    = a;
                        cnt_d    = shamt;
                        state_d  = (shamt == '0) ? IDLE : SHIFT;
                    end
`endif
                    default: begin
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
        end else if (flush) begin
            state_d = IDLE;
        end else begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
                result_d = acc_q << 1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        end
        zero_d = done_d ? (result_d == '0) : zero_q;
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end
    assign result     = result_q;
    assign zero       = zero_q;
    assign done       = done_q;
    assign illegal_op = illegal_q;
`ifdef BARREL_SHIFT_EN
    assign stall = 1'b0;
`else
    assign stall = (state_q == SHIFT);
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed table plus multi-cycle sequences for alu_seq_ctrl
module tb_alu_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  operation;
    logic [63:0] a, b, result;
    logic        zero, done, stall, illegal_op;
    int          n_cmp = 0;
    int          n_fail = 0;

    alu_seq_ctrl #(.WIDTH(64), .SHAMT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation), .a(a), .b(b),
        .flush(flush), .result(result), .zero(zero), .done(done), .stall(stall),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] va, vb, res;
        logic        z, ill;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sll_lat(input int n);
`ifdef BARREL_SHIFT_EN
        return 1;
`else
        return (n == 0) ? 1 : n + 1;
`endif
    endfunction

    task automatic run_sll(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] exp);
        int lat, got, stalls;
        lat = sll_lat(int'(bv[5:0]));
        got = -1;
        stalls = 0;
        start = 1'b1; operation = 4'b0100; a = av; b = bv;
        step();
        start = 1'b0;
        for (int c = 1; c <= lat + 4; c++) begin
            if (done) begin
                got = c;
                break;
            end
            stalls += int'(stall);
            step();
        end
        check("sll_latency", 64'(got), 64'(lat));
        check("sll_stall_cycles", 64'(stalls), 64'(lat - 1));
        check("sll_stall_at_done", {63'd0, stall}, 64'd0);
        check("sll_result", result, exp);
    endtask

    vec_t vecs[10];
    logic [63:0] prev;
    int ndone;

    initial begin
        vecs[0] = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0};
        vecs[1] = '{4'b0110, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0};
        vecs[3] = '{4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0};
        vecs[4] = '{4'b0010, '1, 64'd1, 64'd0, 1'b1, 1'b0};
        vecs[5] = '{4'b0110, 64'd0, 64'd1, '1, 1'b0, 1'b0};
        vecs[6] = '{4'b0011, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1};
        vecs[7] = '{4'b0000, 64'hAA, 64'h55, 64'd0, 1'b1, 1'b0};
        vecs[8] = '{4'b1111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1};
        vecs[9] = '{4'b0100, 64'd1, 64'd64, 64'd1, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; flush = 1'b0; operation = '0; a = '0; b = '0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_result", result, 64'd0);
        check("rst_flags", {59'd0, zero, done, stall, illegal_op, 1'b0}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            start = 1'b1; operation = vecs[i].op; a = vecs[i].va; b = vecs[i].vb;
            step();
            start = 1'b0;
            check($sformatf("v%0d_done", i), {63'd0, done}, 64'd1);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].z});
            check($sformatf("v%0d_illegal", i), {63'd0, illegal_op}, {63'd0, vecs[i].ill});
            check($sformatf("v%0d_stall", i), {63'd0, stall}, 64'd0);
            step();
            check($sformatf("v%0d_done_drop", i), {62'd0, done, illegal_op}, 64'd0);
        end

        run_sll(64'h3, 64'd4, 64'h30);
        start = 1'b1; operation = 4'b0010; a = 64'd1; b = 64'd1;
        step();
        start = 1'b0;
        check("b2b_done", {63'd0, done}, 64'd1);
        check("b2b_result", result, 64'd2);
        step();
        run_sll(64'd1, 64'd63, 64'h8000_0000_0000_0000);
        step();
        run_sll(64'd1, 64'd0, 64'd1);
        step();

        start = 1'b1; flush = 1'b1; operation = 4'b0010; a = 64'd40; b = 64'd2;
        step();
        start = 1'b0; flush = 1'b0;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            ndone += int'(done);
            step();
        end
        check("idle_flush_drop", 64'(ndone), 64'd0);
        check("idle_flush_result", result, 64'd1);

`ifndef BARREL_SHIFT_EN
        prev = result;
        start = 1'b1; operation = 4'b0100; a = 64'd7; b = 64'd10;
        step();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 3; c++) begin
            ndone += int'(done);
            check($sformatf("fl_stall_c%0d", c), {63'd0, stall}, 64'd1);
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        ndone += int'(done);
        check("fl_no_done", 64'(ndone), 64'd0);
        check("fl_stall_drop", {63'd0, stall}, 64'd0);
        check("fl_result_kept", result, prev);
        start = 1'b1; operation = 4'b0010; a = 64'd2; b = 64'd3;
        step();
        start = 1'b0;
        check("fl_add_done", {63'd0, done}, 64'd1);
        check("fl_add_result", result, 64'd5);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            ndone += int'(done);
        end
        check("fl_no_late_done", 64'(ndone), 64'd0);
`endif

        start = 1'b1; operation = 4'b0100; a = 64'd5; b = 64'd20;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_result", result, 64'd0);
        check("midrst_flags", {59'd0, zero, done, stall, illegal_op, 1'b0}, 64'd0);
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            ndone += int'(done) + int'(stall);
        end
        check("midrst_quiet", 64'(ndone), 64'd0);
        check("midrst_result_end", result, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
